// File: rtl/mag_cmp_serial.sv
// ============================================================================
// Module   : mag_cmp_serial
// Brief    : Digit-serial (MSB-first) magnitude comparator, unsigned or signed.
//            Optional MAG_CMP_EARLY_EXIT_EN ends the run on the first differing digit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mag_cmp_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int c_N     = WIDTH / DIGIT;
    localparam int c_CNT_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [WIDTH-1:0] c_SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_bad_digit
            $error("mag_cmp_serial: WIDTH must be an integer multiple of DIGIT");
        end
        if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
            $error("mag_cmp_serial: WIDTH must be in 2..64");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_dec_gt;
    logic               r_dec_lt;

    logic [DIGIT-1:0]   w_da;
    logic [DIGIT-1:0]   w_db;
    logic               w_new_gt;
    logic               w_new_lt;
    logic               w_last;
    logic               w_end;
    logic               w_accept;

    assign w_da     = r_a[WIDTH-1 -: DIGIT];
    assign w_db     = r_b[WIDTH-1 -: DIGIT];
    // Once a digit differs, the decision is frozen for the remaining digits.
    assign w_new_gt = (r_dec_gt | r_dec_lt) ? r_dec_gt : (w_da > w_db);
    assign w_new_lt = (r_dec_gt | r_dec_lt) ? r_dec_lt : (w_da < w_db);
    assign w_last   = (r_cnt == c_CNT_W'(c_N - 1));

`ifdef MAG_CMP_EARLY_EXIT_EN
    assign w_end = w_last | w_new_gt | w_new_lt;
`else
    assign w_end = w_last;
`endif

    assign w_accept = start & ((r_state == IDLE) | (r_state == DONE));
    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = RUN;
            RUN:     if (w_end)    w_state_nxt = DONE;
            DONE:    w_state_nxt = w_accept ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_dec_gt <= 1'b0;
            r_dec_lt <= 1'b0;
            gt       <= 1'b0;
            eq       <= 1'b0;
            lt       <= 1'b0;
        end else if (w_accept) begin
            // Offset-binary in signed mode lets the unsigned digit compare give signed order.
            r_a      <= signed_mode ? (a ^ c_SIGN_BIT) : a;
            r_b      <= signed_mode ? (b ^ c_SIGN_BIT) : b;
            r_cnt    <= '0;
            r_dec_gt <= 1'b0;
            r_dec_lt <= 1'b0;
            gt       <= 1'b0;
            eq       <= 1'b0;
            lt       <= 1'b0;
        end else if (r_state == RUN) begin
            r_a      <= r_a << DIGIT;
            r_b      <= r_b << DIGIT;
            r_cnt    <= r_cnt + 1'b1;
            r_dec_gt <= w_new_gt;
            r_dec_lt <= w_new_lt;
            if (w_end) begin
                gt <= w_new_gt;
                lt <= w_new_lt;
                eq <= ~(w_new_gt | w_new_lt);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mag_cmp_serial.sv
// ============================================================================
// Module   : tb_mag_cmp_serial
// Brief    : Self-checking bench for mag_cmp_serial (WIDTH=8, DIGIT=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mag_cmp_serial;

    localparam int c_TMO = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       sm = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, gt, eq, lt;

    int errors = 0;
    int checks = 0;

    mag_cmp_serial #(.WIDTH(8), .DIGIT(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .signed_mode(sm),
        .busy       (busy),
        .done       (done),
        .gt         (gt),
        .eq         (eq),
        .lt         (lt)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
        if (s) return {$signed(x) > $signed(y), x == y, $signed(x) < $signed(y)};
        return {x > y, x == y, x < y};
    endfunction

    function automatic int exp_lat(input logic [7:0] x, input logic [7:0] y);
`ifdef MAG_CMP_EARLY_EXIT_EN
        logic [7:0] d;
        d = x ^ y;
        for (int i = 0; i < 4; i++) begin
            if (((d >> (6 - 2 * i)) & 8'h03) != 8'h00) return i + 1;
        end
        return 4;
`else
        return 4;
`endif
    endfunction

    // Drives one comparison; returns cycles from the accepting edge to done.
    task automatic do_cmp(input logic [7:0] x, input logic [7:0] y, input logic s,
                          output int lat, output logic [2:0] res);
        @(negedge clk);
        a = x; b = y; sm = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < c_TMO) begin
            @(negedge clk);
            lat++;
        end
        res = {gt, eq, lt};
    endtask

    task automatic test_reset();
        int lat;
        reset_n = 1'b0; start = 1'b1; a = 8'h01; b = 8'h02; sm = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, gt, eq, lt} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state: got %b want 00000", {busy, done, gt, eq, lt});
        end
        reset_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL first_start_accept: busy=%b want 1", busy);
        end
        lat = 0;
        while (done !== 1'b1 && lat < c_TMO) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if ({gt, eq, lt} !== 3'b001 || lat != 4) begin
            errors++;
            $display("FAIL first_start_result: gel=%b lat=%0d want 001 lat=4", {gt, eq, lt}, lat);
        end
    endtask

    task automatic test_directed();
        logic [7:0] xs [4] = '{8'hA5, 8'h80, 8'h80, 8'h3C};
        logic [7:0] ys [4] = '{8'hA4, 8'h7F, 8'h7F, 8'h3C};
        logic       ss [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int lat;
        logic [2:0] res;
        for (int i = 0; i < 4; i++) begin
            do_cmp(xs[i], ys[i], ss[i], lat, res);
            checks++;
            if (res !== model(xs[i], ys[i], ss[i]) || lat != exp_lat(xs[i], ys[i])) begin
                errors++;
                $display("FAIL directed_%0d: gel=%b lat=%0d want gel=%b lat=%0d",
                         i, res, lat, model(xs[i], ys[i], ss[i]), exp_lat(xs[i], ys[i]));
            end
            @(negedge clk);
            checks++;
            if ({busy, done} !== 2'b00 || {gt, eq, lt} !== model(xs[i], ys[i], ss[i])) begin
                errors++;
                $display("FAIL directed_hold_%0d: busy=%b done=%b gel=%b want 0 0 %b",
                         i, busy, done, {gt, eq, lt}, model(xs[i], ys[i], ss[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] x, y;
        logic       s;
        int lat;
        logic [2:0] res;
        for (int i = 0; i < 40; i++) begin
            x = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       y = x;
                1:       y = {x[7:4], 4'($urandom)};
                default: y = 8'($urandom);
            endcase
            s = 1'($urandom);
            do_cmp(x, y, s, lat, res);
            checks++;
            if (res !== model(x, y, s) || lat != exp_lat(x, y)) begin
                errors++;
                $display("FAIL random_%0d a=%h b=%h s=%b: gel=%b lat=%0d want gel=%b lat=%0d",
                         i, x, y, s, res, lat, model(x, y, s), exp_lat(x, y));
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        a = 8'h10; b = 8'h20; sm = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < c_TMO) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                a = 8'hFF; b = 8'h00; start = 1'b1;
            end else if (lat == 2) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if ({gt, eq, lt} !== 3'b001 || lat != exp_lat(8'h10, 8'h20)) begin
            errors++;
            $display("FAIL ignore_start: gel=%b lat=%0d want 001 lat=%0d",
                     {gt, eq, lt}, lat, exp_lat(8'h10, 8'h20));
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL ignore_start_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [2:0] res;
        @(negedge clk);
        a = 8'h05; b = 8'h06; sm = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL mid_run_busy: busy=%b done=%b want 1 0", busy, done);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, gt, eq, lt} !== 5'b0) begin
            errors++;
            $display("FAIL mid_run_reset: got %b want 00000", {busy, done, gt, eq, lt});
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL mid_run_no_done: busy=%b done=%b want 0 0", busy, done);
        end
        do_cmp(8'h01, 8'h02, 1'b0, lat, res);
        checks++;
        if (res !== 3'b001 || lat != 4) begin
            errors++;
            $display("FAIL after_reset_cmp: gel=%b lat=%0d want 001 lat=4", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [2:0] res;
        do_cmp(8'h12, 8'h34, 1'b0, lat, res);
        checks++;
        if (done !== 1'b1 || res !== 3'b001) begin
            errors++;
            $display("FAIL b2b_first: done=%b gel=%b want 1 001", done, res);
        end
        a = 8'h40; b = 8'h40; sm = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_no_idle: busy=%b done=%b want 1 0", busy, done);
        end
        lat = 0;
        while (done !== 1'b1 && lat < c_TMO) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if ({gt, eq, lt} !== 3'b010 || lat != 4) begin
            errors++;
            $display("FAIL b2b_second: gel=%b lat=%0d want 010 lat=4", {gt, eq, lt}, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
